// File: rtl/fnd_scan_controller.sv
// -----------------------------------------------------------------------------
// fnd_scan_controller
//
// Drives the 4-digit FND display path. A binary value (0..9999) is captured
// on a load strobe and converted to four BCD digits by a sequential
// double-dabble engine (one shift per clock, 14 shifts). The finished digits
// are latched into display registers. A free-running prescaler then
// time-multiplexes those digits onto the BCD-to-FND decoder.
//
// Parameters:
//   SCAN_DIV       clock cycles per digit slot (1..2^20)
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        synchronous, active-high reset
//   i_value[13:0]  binary value to display (values above 9999 are clamped)
//   i_load         one-cycle strobe, accepted only while o_busy is low
//   o_busy         conversion in progress
//   o_overflow     last accepted value exceeded 9999
//   o_sum[3:0]     BCD nibble of the selected digit (to decoder i_sum)
//   o_digitSelect  selected digit, 0 = ones .. 3 = thousands
//   o_en           active-high blank for the selected digit (to decoder i_en)
//
// Build option:
//   FND_LEADING_ZERO_BLANK_EN  when defined, leading zero digits (never the
//                              ones digit) are blanked through o_en; when
//                              undefined, o_en is tied low.
// -----------------------------------------------------------------------------
module fnd_scan_controller #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [13:0] i_value,
  input  logic        i_load,
  output logic        o_busy,
  output logic        o_overflow,
  output logic [3:0]  o_sum,
  output logic [1:0]  o_digitSelect,
  output logic        o_en
);

  localparam int                 PRESC_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [13:0]        BIN_MAX    = 14'd9999;
  // Iteration counter value on the 14th (final) shift.
  localparam logic [3:0]         LAST_ITER  = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [13:0]        bin_q,   bin_d;
  logic [15:0]        acc_q,   acc_d;
  logic [3:0]         iter_q,  iter_d;
  logic               ovf_q,   ovf_d;
  logic [15:0]        disp_q,  disp_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [1:0]         idx_q,   idx_d;
  logic               wrap;

  // Double-dabble correction: any BCD nibble of 5 or more gets +3, so that
  // the following left shift carries correctly into the next decade.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] acc);
    logic [15:0] r;
    r = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Conversion FSM: next state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    iter_d  = iter_q;
    ovf_d   = ovf_q;
    disp_d  = disp_q;

    case (state_q)
      S_IDLE: begin
        if (i_load) begin
          bin_d   = (i_value > BIN_MAX) ? BIN_MAX : i_value;
          ovf_d   = (i_value > BIN_MAX);
          acc_d   = '0;
          iter_d  = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        {acc_d, bin_d} = {dabble_adjust(acc_q), bin_q} << 1;
        iter_d         = iter_q + 4'd1;
        if (iter_q == LAST_ITER) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // Only place the shown digits change; the previous value stays up
        // for the whole conversion.
        disp_d  = acc_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scan prescaler and digit index (free-running, independent of the FSM)
  // ---------------------------------------------------------------------------
  always_comb begin
    wrap    = (presc_q == PRESC_LAST);
    presc_d = wrap ? '0 : presc_q + PRESC_W'(1);
    idx_d   = wrap ? idx_q + 2'd1 : idx_q;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      ovf_q   <= 1'b0;
      disp_q  <= '0;
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  // Shift datapath needs no reset: it is fully reloaded on every accepted load.
  always_ff @(posedge i_clk) begin
    bin_q  <= bin_d;
    acc_q  <= acc_d;
    iter_q <= iter_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs (combinational from registered state)
  // ---------------------------------------------------------------------------
  assign o_busy        = (state_q != S_IDLE);
  assign o_overflow    = ovf_q;
  assign o_digitSelect = idx_q;
  assign o_sum         = disp_q[{idx_q, 2'b00} +: 4];

`ifdef FND_LEADING_ZERO_BLANK_EN
  // Bit d is set when digits d..3 are all zero; the ones digit is never
  // blanked so a value of zero still shows a single "0".
  function automatic logic [3:0] leading_zero_mask(input logic [15:0] d);
    logic [3:0] m;
    logic       run;
    m   = '0;
    run = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      run  = run & (d[4*i +: 4] == 4'd0);
      m[i] = run;
    end
    return m;
  endfunction

  logic [3:0] blank_mask;
  assign blank_mask = leading_zero_mask(disp_q);
  assign o_en       = blank_mask[idx_q];
`else
  assign o_en = 1'b0;
`endif

endmodule
